// File: rtl/smbsb_ctrl.sv
// Frame controller feeding the 4x4 serial bit-steering demux: start bit, 2 address bits, 4 data bits.
// Optional even-parity check enabled by defining SMBSB_CTRL_PARITY_EN.
module smbsb_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       serin,
    output logic [1:0] LB,
    output logic [3:0] PB,
    output logic       sample,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef SMBSB_CTRL_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       acnt_q, acnt_d;
    logic [1:0] dcnt_q, dcnt_d;
`ifdef SMBSB_CTRL_PARITY_EN
    logic       acc_q, acc_d;
    logic       err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 2'd0;
            acnt_q  <= 1'b0;
            dcnt_q  <= 2'd0;
`ifdef SMBSB_CTRL_PARITY_EN
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
`ifdef SMBSB_CTRL_PARITY_EN
            acc_q   <= acc_d;
            err_q   <= err_d;
`endif
        end
    end

    // The line is never re-checked inside a frame; every bit is taken as sampled.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
`ifdef SMBSB_CTRL_PARITY_EN
        acc_d   = acc_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!serin) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_d = {addr_q[0], serin};
                acnt_d = acnt_q + 1'b1;
`ifdef SMBSB_CTRL_PARITY_EN
                acc_d  = acc_q ^ serin;
`endif
                if (acnt_q) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                dcnt_d = dcnt_q + 2'd1;
`ifdef SMBSB_CTRL_PARITY_EN
                acc_d  = acc_q ^ serin;
`endif
                if (dcnt_q == 2'd3) begin
`ifdef SMBSB_CTRL_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SMBSB_CTRL_PARITY_EN
            S_PAR: begin
                err_d   = acc_q ^ serin;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
`ifdef SMBSB_CTRL_PARITY_EN
                acc_d   = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so serin never reaches them combinationally.
    always_comb begin
        sample = (state_q == S_DATA);
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        LB     = sample ? dcnt_q : 2'd0;
        PB     = sample ? (4'b0001 << addr_q) : 4'b0000;
`ifdef SMBSB_CTRL_PARITY_EN
        err    = done & err_q;
`else
        err    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_smbsb_ctrl.sv
// Scoreboard bench for smbsb_ctrl: frames push expected demux controls and done/err,
// a negedge monitor pops and compares them.
module tb_smbsb_ctrl;

    logic       clk;
    logic       rst;
    logic       serin;
    logic [1:0] LB;
    logic [3:0] PB;
    logic       sample;
    logic       busy;
    logic       done;
    logic       err;

`ifdef SMBSB_CTRL_PARITY_EN
    localparam int FRAME_LEN = 9;
    localparam int BUSY_LEN  = 8;
`else
    localparam int FRAME_LEN = 8;
    localparam int BUSY_LEN  = 7;
`endif

    typedef struct {
        logic [3:0] pb;
        logic [1:0] lb;
        logic       b;
    } data_exp_t;

    typedef struct {
        logic err;
        logic chk_spacing;
    } done_exp_t;

    data_exp_t data_q[$];
    done_exp_t done_q[$];

    int checks;
    int errors;
    int cyc;
    int last_done;
    int busy_cnt;
    bit mon_en;

    smbsb_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .serin  (serin),
        .LB     (LB),
        .PB     (PB),
        .sample (sample),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitorStep();
        data_exp_t de;
        done_exp_t dn;
        cyc++;
        if (!mon_en) begin
            busy_cnt = 0;
            return;
        end
        if (sample) begin
            if (data_q.size() == 0) begin
                checkOutput("unexpected_sample", 32'(sample), 32'd0);
            end else begin
                de = data_q.pop_front();
                checkOutput("pb", 32'(PB), 32'(de.pb));
                checkOutput("lb", 32'(LB), 32'(de.lb));
                checkOutput("data_bit", 32'(serin), 32'(de.b));
            end
        end else begin
            checkOutput("pb_outside", 32'(PB), 32'd0);
            checkOutput("lb_outside", 32'(LB), 32'd0);
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                dn = done_q.pop_front();
                checkOutput("err", 32'(err), 32'(dn.err));
                if (dn.chk_spacing) begin
                    checkOutput("spacing", 32'(cyc - last_done), 32'(FRAME_LEN));
                end
            end
            last_done = cyc;
        end else begin
            checkOutput("err_no_done", 32'(err), 32'd0);
        end
        if (busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            checkOutput("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
            busy_cnt = 0;
        end
    endtask

    // Drives one frame starting from IDLE; next_b2b keeps the line low through DONE
    // so the following frame's start bit lands on the first IDLE cycle.
    task automatic applyStimulus(input logic [1:0] a, input logic [3:0] d, input logic p,
                                 input bit next_b2b, input bit chk_spacing);
        data_exp_t de;
        done_exp_t dn;
        serin = 1'b0;
        step();
        serin = a[1];
        step();
        serin = a[0];
        step();
        for (int k = 0; k < 4; k++) begin
            de.pb = 4'b0001 << a;
            de.lb = 2'(k);
            de.b  = d[k];
            data_q.push_back(de);
            serin = d[k];
            step();
        end
`ifdef SMBSB_CTRL_PARITY_EN
        dn.err = (^{a, d}) ^ p;
        serin  = p;
        step();
`else
        dn.err = 1'b0;
`endif
        dn.chk_spacing = chk_spacing;
        done_q.push_back(dn);
        serin = next_b2b ? 1'b0 : 1'b1;
        step();
        if (!next_b2b) begin
            serin = 1'b1;
            step();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        last_done = 0;
        busy_cnt  = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        serin     = 1'b1;

        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pb", 32'(PB), 32'd0);
        checkOutput("rst_lb", 32'(LB), 32'd0);
        checkOutput("rst_sample", 32'(sample), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Frame to port 2 interrupted by reset in the middle of DATA.
        serin = 1'b0;
        step();
        serin = 1'b1;
        step();
        serin = 1'b0;
        step();
        serin = 1'b1;
        step();
        @(negedge clk);
        checkOutput("mid_pb", 32'(PB), 32'h4);
        checkOutput("mid_lb", 32'(LB), 32'd1);
        checkOutput("mid_sample", 32'(sample), 32'd1);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        serin = 1'b0;
        step();
        @(negedge clk);
        checkOutput("abort_pb", 32'(PB), 32'd0);
        checkOutput("abort_lb", 32'(LB), 32'd0);
        checkOutput("abort_sample", 32'(sample), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        serin = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'({busy, done}), 32'd0);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Port 2, data bits 1,0,1,1 in LSB-first order.
        applyStimulus(2'd2, 4'b1101, 1'b0, 1'b0, 1'b0);

        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'(a), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        serin = 1'b1;
        repeat (50) begin
            @(negedge clk);
            checkOutput("idle_line", 32'({busy, sample, done}), 32'd0);
        end
        @(posedge clk);
        #1;

        applyStimulus(2'd1, 4'b1010, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'd3, 4'b0110, 1'b1, 1'b1, 1'b1);
        applyStimulus(2'd0, 4'b1001, 1'b0, 1'b0, 1'b1);

`ifdef SMBSB_CTRL_PARITY_EN
        applyStimulus(2'd1, 4'b0011, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'd1, 4'b0011, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        repeat (4) step();
        checkOutput("data_q_empty", 32'(data_q.size()), 32'd0);
        checkOutput("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
